// File: rtl/scanline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scanline_sequencer
// Description : Sequences the increment-and-compare delay array over a full
//               sector scan. Each line configures the array with r_0 and the
//               current steering angle, then walks every scanpoint. Each ready
//               delay set is handed to the transmit path and acknowledged back
//               to the array. The last point of each line is flagged, and the
//               angle advances between lines.
// Revision    : 1.0 - initial release
// ============================================================================
module scanline_sequencer #(
  parameter int DW_INPUT = 8,
  parameter int DW_ANGLE = 8,
  parameter int DW_POINT = 10,
  parameter int DW_LINE  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DW_INPUT-1:0] cfg_r_0,
  input  logic [DW_ANGLE-1:0] cfg_angle_start,
  input  logic [DW_ANGLE-1:0] cfg_angle_step,
  input  logic [DW_LINE-1:0]  cfg_num_lines,
  input  logic [DW_POINT-1:0] cfg_num_points,
  input  logic                array_done_configuring,
  input  logic                array_ready,
  input  logic                transmit_done,
  output logic [DW_INPUT-1:0] r_0,
  output logic [DW_ANGLE-1:0] angle,
  output logic                configure,
  output logic                ack,
  output logic                final_scanpoint,
  output logic                tx_valid,
  output logic [DW_POINT-1:0] point_idx,
  output logic [DW_LINE-1:0]  line_idx,
  output logic                busy,
  output logic                scan_done,
  output logic                aborted
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CONFIG     = 4'd1,
    S_WAIT_CFG   = 4'd2,
    S_WAIT_READY = 4'd3,
    S_TRANSMIT   = 4'd4,
    S_ACK        = 4'd5,
    S_GUARD      = 4'd6,
    S_DONE       = 4'd7,
    S_ABORT      = 4'd8
  } state_t;

  state_t              state_q;
  logic [DW_ANGLE-1:0] angle_step_q;
  logic [DW_LINE-1:0]  num_lines_q;
  logic [DW_POINT-1:0] num_points_q;

  logic [DW_INPUT-1:0] r_0_q;
  logic [DW_ANGLE-1:0] angle_q;
  logic                configure_q;
  logic                ack_q;
  logic                final_scanpoint_q;
  logic                tx_valid_q;
  logic [DW_POINT-1:0] point_idx_q;
  logic [DW_LINE-1:0]  line_idx_q;
  logic                busy_q;
  logic                scan_done_q;
  logic                aborted_q;

  logic                last_point_d;
  logic                last_line_d;
  logic                abort_take_d;

  // Position decode and abort qualification (abort only matters mid-scan)
  always_comb begin
    last_point_d = (point_idx_q == (num_points_q - DW_POINT'(1)));
    last_line_d  = (line_idx_q == (num_lines_q - DW_LINE'(1)));
    abort_take_d = abort && (state_q inside {S_CONFIG, S_WAIT_CFG, S_WAIT_READY,
                                             S_TRANSMIT, S_ACK, S_GUARD});
  end

  // Scan FSM; every output is produced as a register alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      angle_step_q      <= '0;
      num_lines_q       <= '0;
      num_points_q      <= '0;
      r_0_q             <= '0;
      angle_q           <= '0;
      configure_q       <= 1'b0;
      ack_q             <= 1'b0;
      final_scanpoint_q <= 1'b0;
      tx_valid_q        <= 1'b0;
      point_idx_q       <= '0;
      line_idx_q        <= '0;
      busy_q            <= 1'b0;
      scan_done_q       <= 1'b0;
      aborted_q         <= 1'b0;
    end else begin
      // Pulse outputs default low; a state sets them for a single cycle
      configure_q       <= 1'b0;
      ack_q             <= 1'b0;
      final_scanpoint_q <= 1'b0;
      scan_done_q       <= 1'b0;
      aborted_q         <= 1'b0;
      if (abort_take_d) begin
        // Abort wins over any transition, including a coincident transmit_done
        state_q           <= S_ABORT;
        final_scanpoint_q <= 1'b1;
        aborted_q         <= 1'b1;
        tx_valid_q        <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              r_0_q        <= cfg_r_0;
              angle_q      <= cfg_angle_start;
              angle_step_q <= cfg_angle_step;
              num_lines_q  <= cfg_num_lines;
              num_points_q <= cfg_num_points;
              line_idx_q   <= '0;
              point_idx_q  <= '0;
              busy_q       <= 1'b1;
              if ((cfg_num_lines == '0) || (cfg_num_points == '0)) begin
                state_q <= S_DONE;
              end else begin
                state_q     <= S_CONFIG;
                configure_q <= 1'b1;
              end
            end
          end
          S_CONFIG: state_q <= S_WAIT_CFG;
          S_WAIT_CFG: begin
            if (array_done_configuring) state_q <= S_WAIT_READY;
          end
          S_WAIT_READY: begin
            if (array_ready) begin
              tx_valid_q <= 1'b1;
              state_q    <= S_TRANSMIT;
            end
          end
          S_TRANSMIT: begin
            if (transmit_done) begin
              tx_valid_q        <= 1'b0;
              ack_q             <= 1'b1;
              final_scanpoint_q <= last_point_d;
              state_q           <= S_ACK;
            end
          end
          // ACK output already registered on entry; GUARD gives the array a
          // cycle to drop array_ready before it is sampled again
          S_ACK: state_q <= S_GUARD;
          S_GUARD: begin
            if (last_point_d) begin
              if (last_line_d) begin
                state_q <= S_DONE;
              end else begin
                line_idx_q  <= line_idx_q + DW_LINE'(1);
                angle_q     <= angle_q + angle_step_q;
                point_idx_q <= '0;
                configure_q <= 1'b1;
                state_q     <= S_CONFIG;
              end
            end else begin
              point_idx_q <= point_idx_q + DW_POINT'(1);
              state_q     <= S_WAIT_READY;
            end
          end
          S_DONE: begin
            scan_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
          S_ABORT: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign r_0             = r_0_q;
  assign angle           = angle_q;
  assign configure       = configure_q;
  assign ack             = ack_q;
  assign final_scanpoint = final_scanpoint_q;
  assign tx_valid        = tx_valid_q;
  assign point_idx       = point_idx_q;
  assign line_idx        = line_idx_q;
  assign busy            = busy_q;
  assign scan_done       = scan_done_q;
  assign aborted         = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_scanline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanline_sequencer
// Description : Bench for scanline_sequencer. A scan model expands each
//               configuration into the ordered list of configure and ack
//               events, and a per-cycle monitor checks the DUT against it.
//               Directed literal checks pin latencies and event counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scanline_sequencer;

  localparam int DW_INPUT = 8;
  localparam int DW_ANGLE = 8;
  localparam int DW_POINT = 10;
  localparam int DW_LINE  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic [DW_INPUT-1:0] cfg_r_0;
  logic [DW_ANGLE-1:0] cfg_angle_start;
  logic [DW_ANGLE-1:0] cfg_angle_step;
  logic [DW_LINE-1:0]  cfg_num_lines;
  logic [DW_POINT-1:0] cfg_num_points;
  logic                array_done_configuring;
  logic                array_ready;
  logic                transmit_done;
  logic [DW_INPUT-1:0] r_0;
  logic [DW_ANGLE-1:0] angle;
  logic                configure;
  logic                ack;
  logic                final_scanpoint;
  logic                tx_valid;
  logic [DW_POINT-1:0] point_idx;
  logic [DW_LINE-1:0]  line_idx;
  logic                busy;
  logic                scan_done;
  logic                aborted;

  scanline_sequencer #(
    .DW_INPUT(DW_INPUT), .DW_ANGLE(DW_ANGLE), .DW_POINT(DW_POINT), .DW_LINE(DW_LINE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_r_0(cfg_r_0), .cfg_angle_start(cfg_angle_start),
    .cfg_angle_step(cfg_angle_step), .cfg_num_lines(cfg_num_lines),
    .cfg_num_points(cfg_num_points),
    .array_done_configuring(array_done_configuring),
    .array_ready(array_ready), .transmit_done(transmit_done),
    .r_0(r_0), .angle(angle), .configure(configure), .ack(ack),
    .final_scanpoint(final_scanpoint), .tx_valid(tx_valid),
    .point_idx(point_idx), .line_idx(line_idx), .busy(busy),
    .scan_done(scan_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  typedef struct { int line; int angle; } cfg_ev_t;
  typedef struct { int line; int point; bit last; } ack_ev_t;

  cfg_ev_t exp_cfg[$];
  ack_ev_t exp_ack[$];
  int      exp_r0;

  int n_vec  = 0;
  int n_fail = 0;

  int cyc = 0, cfg_cnt = 0, ack_cnt = 0, fsp_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int obs_angle[$];
  int obs_point[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expand one scan into its event lists: line l is configured with
  // angle_start + l*step (mod 256) and then acks points 0..points-1.
  task automatic model_scan(input int lines, input int points, input int a0,
                            input int step, input int r0);
    exp_r0 = r0;
    if (lines == 0 || points == 0) return;
    for (int l = 0; l < lines; l++) begin
      exp_cfg.push_back('{line: l, angle: (a0 + l * step) % 256});
      for (int p = 0; p < points; p++)
        exp_ack.push_back('{line: l, point: p, last: (p == points - 1)});
    end
  endtask

  task automatic flush_model();
    exp_cfg.delete();
    exp_ack.delete();
  endtask

  // ------------------------------------------------------------------ monitor
  initial begin : monitor
    bit prev_td, prev_txv, prev_abort, prev_rst;
    int last_ack_cyc;
    cfg_ev_t ce;
    ack_ev_t ae;
    prev_td = 0; prev_txv = 0; prev_abort = 0; prev_rst = 1; last_ack_cyc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (configure) begin
          cfg_cnt++;
          obs_angle.push_back(int'(angle));
          chk("configure_expected", exp_cfg.size() > 0, 1);
          if (exp_cfg.size() > 0) begin
            ce = exp_cfg.pop_front();
            chk("cfg_angle", angle, ce.angle);
            chk("cfg_line_idx", line_idx, ce.line);
            chk("cfg_point_idx", point_idx, 0);
            chk("cfg_r_0", r_0, exp_r0);
          end
        end
        if (ack) begin
          ack_cnt++;
          last_ack_cyc = cyc;
          obs_point.push_back(int'(point_idx));
          chk("ack_expected", exp_ack.size() > 0, 1);
          chk("ack_follows_transmit_done", prev_td && prev_txv, 1);
          chk("ack_tx_valid_low", tx_valid, 0);
          if (exp_ack.size() > 0) begin
            ae = exp_ack.pop_front();
            chk("ack_line_idx", line_idx, ae.line);
            chk("ack_point_idx", point_idx, ae.point);
            chk("ack_final_scanpoint", final_scanpoint, ae.last);
          end
        end
        if (prev_td && prev_txv && !prev_abort && !prev_rst)
          chk("transmit_done_gives_ack", ack, 1);
        if (final_scanpoint) begin
          fsp_cnt++;
          if (!ack) chk("final_scanpoint_without_ack_is_abort", aborted, 1);
        end
        if (aborted) begin
          abort_cnt++;
          chk("abort_fsp", final_scanpoint, 1);
          chk("abort_tx_valid", tx_valid, 0);
          chk("abort_no_ack", ack, 0);
          chk("abort_no_scan_done", scan_done, 0);
        end
        if (scan_done) begin
          done_cnt++;
          chk("scan_done_events_remaining", exp_cfg.size() + exp_ack.size(), 0);
        end
        if (configure || ack || scan_done)
          chk("pulse_exclusive", int'(configure) + int'(ack) + int'(scan_done), 1);
        if (tx_valid && !prev_txv && last_ack_cyc >= 0)
          chk("tx_valid_gap_after_ack", (cyc - last_ack_cyc) >= 2, 1);
      end
      prev_td    = transmit_done;
      prev_txv   = tx_valid;
      prev_abort = abort;
      prev_rst   = rst;
    end
  end

  // ----------------------------------------------- array / transmit responder
  // mode 0: idle, 1: ready 4 cycles after configure/ack and done_configuring
  // 2 cycles after configure, 2: both levels held high. transmit_done pulses
  // 2 cycles after tx_valid rises in modes 1 and 2.
  int resp_mode = 0;

  initial begin : responder
    int dc_t, rd_t, tx_t;
    bit tx_prev;
    dc_t = 0; rd_t = 0; tx_t = 0; tx_prev = 0;
    array_done_configuring = 0; array_ready = 0; transmit_done = 0;
    forever begin
      @(posedge clk); #1;
      transmit_done = 0;
      if (resp_mode != 0) begin
        if (resp_mode == 2) begin
          array_done_configuring = 1;
          array_ready = 1;
        end else begin
          if (configure) begin
            array_done_configuring = 0; dc_t = 2;
          end else if (dc_t > 0) begin
            dc_t--;
            if (dc_t == 0) array_done_configuring = 1;
          end
          if (configure || ack) begin
            array_ready = 0; rd_t = 4;
          end else if (rd_t > 0) begin
            rd_t--;
            if (rd_t == 0) array_ready = 1;
          end
        end
        if (tx_valid && !tx_prev) tx_t = 2;
        else if (tx_t > 0) begin
          tx_t--;
          if (tx_t == 0) transmit_done = 1;
        end
      end
      tx_prev = tx_valid;
    end
  end

  // ------------------------------------------------------------ main sequence
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int lines, input int points, input int a0,
                          input int step, input int r0);
    cfg_num_lines   = DW_LINE'(lines);
    cfg_num_points  = DW_POINT'(points);
    cfg_angle_start = DW_ANGLE'(a0);
    cfg_angle_step  = DW_ANGLE'(step);
    cfg_r_0         = DW_INPUT'(r0);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int base, input int limit, input string nm);
    int k;
    k = 0;
    while (done_cnt == base && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    chk(nm, done_cnt > base, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, a0, f0, d0, ab0, k;
    bit found;
    int exp_pts[6];
    exp_pts = '{0, 1, 2, 0, 1, 2};

    rst = 1; start = 0; abort = 0;
    cfg_r_0 = 0; cfg_angle_start = 0; cfg_angle_step = 0;
    cfg_num_lines = 0; cfg_num_points = 0;
    repeat (3) tick();
    chk("reset_outputs_zero",
        {r_0, angle, configure, ack, final_scanpoint, tx_valid, point_idx,
         line_idx, busy, scan_done, aborted}, 0);
    rst = 0;
    resp_mode = 1;
    tick();

    // Nominal scan, with a spurious start while busy
    obs_angle.delete(); obs_point.delete();
    c0 = cfg_cnt; a0 = ack_cnt; f0 = fsp_cnt; d0 = done_cnt;
    model_scan(2, 3, 10, 5, 40);
    do_start(2, 3, 10, 5, 40);
    chk("start_to_configure_latency", configure, 1);
    chk("busy_after_start", busy, 1);
    repeat (3) tick();
    do_start(1, 1, 99, 77, 7);
    wait_done(d0, 400, "nominal_scan_done_timeout");
    chk("nominal_configure_count", cfg_cnt - c0, 2);
    chk("nominal_ack_count", ack_cnt - a0, 6);
    chk("nominal_fsp_count", fsp_cnt - f0, 2);
    chk("nominal_done_count", done_cnt - d0, 1);
    chk("nominal_angle_line0", obs_angle.size() > 0 ? obs_angle[0] : -1, 10);
    chk("nominal_angle_line1", obs_angle.size() > 1 ? obs_angle[1] : -1, 15);
    for (int i = 0; i < 6; i++)
      chk("nominal_point_seq", obs_point.size() > i ? obs_point[i] : -1, exp_pts[i]);
    chk("r_0_held_after_scan", r_0, 40);
    chk("line_idx_held_after_scan", line_idx, 1);
    chk("point_idx_held_after_scan", point_idx, 2);
    tick();
    chk("idle_busy_low", busy, 0);

    // array_ready held high across acks
    a0 = ack_cnt; d0 = done_cnt;
    resp_mode = 2;
    model_scan(1, 3, 0, 0, 9);
    do_start(1, 3, 0, 0, 9);
    wait_done(d0, 200, "held_ready_done_timeout");
    chk("held_ready_ack_count", ack_cnt - a0, 3);
    resp_mode = 1;
    tick();

    // Angle wrap
    obs_angle.delete();
    d0 = done_cnt;
    model_scan(2, 1, 250, 10, 3);
    do_start(2, 1, 250, 10, 3);
    wait_done(d0, 300, "wrap_done_timeout");
    chk("wrap_angle_line0", obs_angle.size() > 0 ? obs_angle[0] : -1, 250);
    chk("wrap_angle_line1", obs_angle.size() > 1 ? obs_angle[1] : -1, 4);
    tick();

    // Zero line count and zero point count
    for (int z = 0; z < 2; z++) begin
      c0 = cfg_cnt;
      model_scan(z == 0 ? 0 : 3, z == 0 ? 5 : 0, 1, 1, 1);
      do_start(z == 0 ? 0 : 3, z == 0 ? 5 : 0, 1, 1, 1);
      chk("zero_count_no_early_done", scan_done, 0);
      tick();
      chk("zero_count_done_at_2", scan_done, 1);
      tick();
      chk("zero_count_done_single", scan_done, 0);
      chk("zero_count_no_configure", cfg_cnt - c0, 0);
      chk("zero_count_idle", busy, 0);
      tick();
    end

    // Abort in TRANSMIT of line 1 point 1 with simultaneous transmit_done
    a0 = ack_cnt; f0 = fsp_cnt; d0 = done_cnt; ab0 = abort_cnt;
    model_scan(2, 3, 20, 1, 50);
    do_start(2, 3, 20, 1, 50);
    found = 0; k = 0;
    while (!found && k < 400) begin
      @(negedge clk);
      k++;
      if (tx_valid && line_idx == 1 && point_idx == 1) found = 1;
    end
    chk("abort_point_reached", found, 1);
    @(posedge clk); #2;
    abort = 1; transmit_done = 1;
    @(posedge clk); #2;
    abort = 0; transmit_done = 0;
    chk("abort_pulse", {aborted, final_scanpoint, tx_valid, ack}, 4'b1100);
    @(posedge clk); #2;
    chk("abort_then_idle", busy, 0);
    chk("abort_ack_count", ack_cnt - a0, 4);
    chk("abort_fsp_count", fsp_cnt - f0, 2);
    chk("abort_aborted_count", abort_cnt - ab0, 1);
    chk("abort_no_scan_done", done_cnt - d0, 0);
    flush_model();
    tick();

    // Reset mid-WAIT_READY
    f0 = fsp_cnt;
    model_scan(1, 2, 30, 0, 60);
    do_start(1, 2, 30, 0, 60);
    repeat (3) tick();
    chk("pre_reset_busy", busy, 1);
    rst = 1;
    tick();
    chk("mid_scan_reset_outputs_zero",
        {r_0, angle, configure, ack, final_scanpoint, tx_valid, point_idx,
         line_idx, busy, scan_done, aborted}, 0);
    rst = 0;
    flush_model();
    repeat (3) tick();
    chk("reset_no_fsp_pulse", fsp_cnt - f0, 0);
    chk("reset_stays_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
